// File: rtl/mc_control_fsm_if.sv
// ----------------------------------------------------------------------------
// mc_control_fsm_if
//   Bundle between the instruction register / status flags and the
//   multi-cycle control unit, plus every datapath control line it drives.
//
//   master : control unit side (samples IR fields/flags, drives controls)
//   slave  : datapath side (drives IR fields/flags, samples controls)
//
//   IR fields / flags : opcode, funct, of_flag, div_zero, md_done
//   Controls          : pc_write, ir_write, mem_rd, reg_write, ab_load,
//                       aluout_load, epc_write, md_start, md_sel, shift_src,
//                       halted, reg_dst, mem_to_reg, alu_op, alu_src_a,
//                       alu_src_b, pc_source, shift_op
//   Status            : cause (exception cause register), state_dbg
// ----------------------------------------------------------------------------
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       of_flag;
    logic       div_zero;
    logic       md_done;

    logic       pc_write;
    logic       ir_write;
    logic       mem_rd;
    logic       reg_write;
    logic       ab_load;
    logic       aluout_load;
    logic       epc_write;
    logic       md_start;
    logic       md_sel;
    logic       shift_src;
    logic       halted;
    logic [1:0] reg_dst;
    logic [2:0] mem_to_reg;
    logic [2:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] shift_op;
    logic [1:0] cause;
    logic [4:0] state_dbg;

    modport master (
        input  opcode, funct, of_flag, div_zero, md_done,
        output pc_write, ir_write, mem_rd, reg_write, ab_load, aluout_load,
               epc_write, md_start, md_sel, shift_src, halted, reg_dst,
               mem_to_reg, alu_op, alu_src_a, alu_src_b, pc_source, shift_op,
               cause, state_dbg
    );

    modport slave (
        output opcode, funct, of_flag, div_zero, md_done,
        input  pc_write, ir_write, mem_rd, reg_write, ab_load, aluout_load,
               epc_write, md_start, md_sel, shift_src, halted, reg_dst,
               mem_to_reg, alu_op, alu_src_a, alu_src_b, pc_source, shift_op,
               cause, state_dbg
    );
endinterface

// File: rtl/mc_control_fsm.sv
// ----------------------------------------------------------------------------
// mc_control_fsm
//   Multi-cycle control sequencer for the MIPS-subset datapath: fetch with
//   MEM_LAT wait cycles, decode, R-type ALU, shifter, mult/div with done
//   handshake and timeout, mfhi/mflo, jr, rte, break (halt) and exception
//   entry.
//
//   Ports:
//     clck  : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : mc_control_fsm_if.master (IR fields, flags, all controls)
//
//   Parameters:
//     MEM_LAT    : cycles spent in FETCH (1..15)
//     MD_TIMEOUT : max MD_WAIT cycles before a timeout exception (1..255)
// ----------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int MEM_LAT    = 1,
    parameter int MD_TIMEOUT = 40
) (
    input  logic               clck,
    input  logic               rst_n,
    mc_control_fsm_if.master   bus
);

    typedef enum logic [4:0] {
        S_INIT     = 5'd0,
        S_FETCH    = 5'd1,
        S_IR_LOAD  = 5'd2,
        S_DECODE   = 5'd3,
        S_EXEC     = 5'd4,
        S_WB_ALU   = 5'd5,
        S_SH_LOAD  = 5'd6,
        S_SH_OP    = 5'd7,
        S_SH_WB    = 5'd8,
        S_MD_START = 5'd9,
        S_MD_WAIT  = 5'd10,
        S_MF_WB    = 5'd11,
        S_JR       = 5'd12,
        S_RTE      = 5'd13,
        S_EXC      = 5'd14,
        S_HALT     = 5'd15
    } state_t;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04, F_SRAV = 6'h07, F_JR   = 6'h08;
    localparam logic [5:0] F_BRK  = 6'h0d, F_MFHI = 6'h10, F_MFLO = 6'h12;
    localparam logic [5:0] F_RTE  = 6'h13, F_MULT = 6'h18, F_DIV  = 6'h1a;
    localparam logic [5:0] F_ADD  = 6'h20, F_SUB  = 6'h22, F_AND  = 6'h24;
    localparam logic [5:0] F_SLT  = 6'h2a;

    localparam logic [7:0] FETCH_LAST = 8'(MEM_LAT - 1);
    localparam logic [7:0] MD_LAST    = 8'(MD_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;      // shared FETCH wait / MD_WAIT timeout counter
    logic [5:0] fn_q, fn_d;        // funct captured in DECODE, drives later states
    logic [1:0] cause_q, cause_d;

    logic addsub_q;
    logic shvar_q;
    assign addsub_q = (fn_q == F_ADD) || (fn_q == F_SUB);
    assign shvar_q  = (fn_q == F_SLLV) || (fn_q == F_SRAV);

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            fn_q    <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fn_q    <= fn_d;
            cause_q <= cause_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fn_d    = fn_q;
        cause_d = cause_q;
        case (state_q)
            S_INIT: begin
                cnt_d   = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (cnt_q == FETCH_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IR_LOAD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_IR_LOAD: state_d = S_DECODE;
            S_DECODE: begin
                fn_d = bus.funct;
                if (bus.opcode != 6'd0) begin
                    state_d = S_EXC;
                    cause_d = 2'b00;
                end else begin
                    case (bus.funct)
                        F_ADD, F_SUB, F_AND, F_SLT:          state_d = S_EXEC;
                        F_SLL, F_SRL, F_SRA, F_SLLV, F_SRAV: state_d = S_SH_LOAD;
                        F_MULT, F_DIV:                       state_d = S_MD_START;
                        F_MFHI, F_MFLO:                      state_d = S_MF_WB;
                        F_JR:                                state_d = S_JR;
                        F_RTE:                               state_d = S_RTE;
                        F_BRK:                               state_d = S_HALT;
                        default: begin
                            state_d = S_EXC;
                            cause_d = 2'b00;
                        end
                    endcase
                end
            end
            S_EXEC: state_d = S_WB_ALU;
            S_WB_ALU: begin
                if (addsub_q && bus.of_flag) begin
                    state_d = S_EXC;
                    cause_d = 2'b01;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_SH_LOAD: state_d = S_SH_OP;
            S_SH_OP:   state_d = S_SH_WB;
            S_SH_WB:   state_d = S_FETCH;
            S_MD_START: begin
                cnt_d   = '0;
                state_d = S_MD_WAIT;
            end
            S_MD_WAIT: begin
                // done has priority over the timeout on the same cycle
                if (bus.md_done) begin
                    cnt_d = '0;
                    if ((fn_q == F_DIV) && bus.div_zero) begin
                        state_d = S_EXC;
                        cause_d = 2'b10;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (cnt_q == MD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_EXC;
                    cause_d = 2'b11;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_MF_WB, S_JR, S_RTE, S_EXC: state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_INIT;
        endcase
    end

    // Outputs from registered state (plus captured funct)
    always_comb begin
        bus.pc_write    = 1'b0;
        bus.ir_write    = 1'b0;
        bus.mem_rd      = 1'b0;
        bus.reg_write   = 1'b0;
        bus.ab_load     = 1'b0;
        bus.aluout_load = 1'b0;
        bus.epc_write   = 1'b0;
        bus.md_start    = 1'b0;
        bus.md_sel      = 1'b0;
        bus.shift_src   = 1'b0;
        bus.halted      = 1'b0;
        bus.reg_dst     = 2'b00;
        bus.mem_to_reg  = 3'b000;
        bus.alu_op      = 3'b000;
        bus.alu_src_a   = 2'b00;
        bus.alu_src_b   = 2'b00;
        bus.pc_source   = 2'b00;
        bus.shift_op    = 3'b000;
        bus.cause       = cause_q;
        bus.state_dbg   = state_q;
        case (state_q)
            S_FETCH: bus.mem_rd = 1'b1;
            S_IR_LOAD: begin
                bus.ir_write  = 1'b1;
                bus.pc_write  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = 3'b001;
            end
            S_DECODE: bus.ab_load = 1'b1;
            S_EXEC: begin
                bus.alu_src_a   = 2'b10;
                bus.aluout_load = 1'b1;
                case (fn_q)
                    F_ADD:   bus.alu_op = 3'b001;
                    F_SUB:   bus.alu_op = 3'b010;
                    F_AND:   bus.alu_op = 3'b011;
                    default: bus.alu_op = 3'b111;
                endcase
            end
            S_WB_ALU: begin
                bus.reg_dst    = 2'b01;
                bus.mem_to_reg = (fn_q == F_SLT) ? 3'b110 : 3'b000;
                // overflow must suppress the write in the same cycle it is seen
                bus.reg_write  = !(addsub_q && bus.of_flag);
            end
            S_SH_LOAD: begin
                bus.shift_op  = 3'b001;
                bus.shift_src = shvar_q;
            end
            S_SH_OP: begin
                bus.shift_src = shvar_q;
                case (fn_q)
                    F_SLL, F_SLLV: bus.shift_op = 3'b010;
                    F_SRL:         bus.shift_op = 3'b011;
                    default:       bus.shift_op = 3'b100;
                endcase
            end
            S_SH_WB: begin
                bus.shift_src  = shvar_q;
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 2'b01;
                bus.mem_to_reg = 3'b100;
            end
            S_MD_START: begin
                bus.md_start = 1'b1;
                bus.md_sel   = (fn_q == F_DIV);
            end
            S_MD_WAIT: bus.md_sel = (fn_q == F_DIV);
            S_MF_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 2'b01;
                bus.mem_to_reg = (fn_q == F_MFHI) ? 3'b010 : 3'b011;
            end
            S_JR: begin
                bus.alu_src_a = 2'b10;
                bus.pc_source = 2'b01;
                bus.pc_write  = 1'b1;
            end
            S_RTE: begin
                bus.pc_source = 2'b11;
                bus.pc_write  = 1'b1;
            end
            S_EXC: begin
                bus.epc_write = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = 3'b010;
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
            end
            S_HALT: bus.halted = 1'b1;
            default: ;
        endcase
    end

endmodule
